ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction-fetch responder that sits between the PC generator and the core bus port.
- Consumes the PC value and fetch-enable strobe, runs a single-outstanding request/grant/response transaction on the instruction bus, and presents the fetched word plus its PC to the IF/ID stage.
- Raises a stall request to ctrl while a fetch is pending.
- Discards in-flight responses when an EX branch redirects the PC.

Parameters:
- ADDR_W, 32, width of PC and bus address.
- DATA_W, 32, width of instruction word.
- NOP_INST, 32'h0000_0013, value driven on inst_o when no valid instruction is held.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous reset, active low.
- pc_i  input  ADDR_W  fetch address from PC register.
- ce_i  input  1  fetch enable from PC register.
- branch_flag_i  input  1  EX branch taken; flushes the current fetch.
- stalled_i  input  5  ctrl stall vector; bit 1 = IF/ID stalled.
- req_o  output  1  bus request.
- addr_o  output  ADDR_W  bus address, word aligned.
- gnt_i  input  1  bus grant for the request.
- rvalid_i  input  1  read data valid.
- rdata_i  input  DATA_W  read data.
- inst_o  output  DATA_W  fetched instruction to IF/ID.
- inst_pc_o  output  ADDR_W  PC of inst_o.
- inst_valid_o  output  1  inst_o holds a valid fetched word.
- stallreq_o  output  1  stall request to ctrl.

Behaviour:
- Reset (rst=0, async): state IDLE, req_o=0, addr_o=0, inst_o=NOP_INST, inst_pc_o=0, inst_valid_o=0, discard flag=0.
- All outputs are registered except stallreq_o, which is combinational: 1 in REQ or WAIT, else 0.
- IDLE: if ce_i=1 and branch_flag_i=0 → next cycle req_o=1, addr_o={pc_i[ADDR_W-1:2],2'b00}, state REQ. Otherwise remain in IDLE.
- REQ: req_o and addr_o are held stable until gnt_i=1. A request is never withdrawn once asserted.
  - On gnt_i=1 → req_o=0 next cycle, state WAIT.
- WAIT: on rvalid_i=1 with discard=0:
  - inst_o=rdata_i, inst_pc_o=addr_o, inst_valid_o=1.
  - If stalled_i[1]=1 → state HOLD.
  - Else if ce_i=1 → back-to-back fetch: req_o=1, addr_o=new pc_i, state REQ.
  - Else → state IDLE.
- HOLD: inst_o, inst_pc_o and inst_valid_o are frozen while stalled_i[1]=1. When stalled_i[1]=0, behave exactly as the WAIT-completion branch (issue the next fetch if ce_i=1, else IDLE).
- Latency: minimum 3 cycles from ce_i sample to inst_valid_o (1 cycle request, gnt and rvalid each arriving the cycle after).
- Flush (branch_flag_i=1):
  - In any state: inst_valid_o=0 and inst_o=NOP_INST next cycle.
  - IDLE or HOLD: state IDLE.
  - REQ: keep req_o asserted, set discard=1.
  - WAIT: set discard=1.
- Discarded response: on rvalid_i=1 with discard=1, rdata_i is dropped, discard clears, and state moves to IDLE. A new fetch is then issued from the current pc_i if ce_i=1.
- Simultaneous branch_flag_i and rvalid_i in WAIT: the flush wins. The word is dropped and inst_valid_o=0.
- Unexpected events: rvalid_i in IDLE, REQ or HOLD, and gnt_i outside REQ, are ignored. These are protocol errors and are flagged by bench assertions.
- Address wrap: none in this block. Any ADDR_W value is passed through, with addr_o[1:0] forced to 00.

Optional Feature:
- Macro: IFU_FETCH_ERR_EN.
- Defined:
  - Adds ports err_i (input, 1; bus error, qualified by rvalid_i) and fetch_err_o (output, 1, reset 0).
  - On a non-discarded response, fetch_err_o=err_i, captured alongside inst_o.
  - fetch_err_o is also set to 1 when pc_i[1:0]!=00 at request issue.
  - fetch_err_o clears on flush or on the next valid capture.
- Undefined: err_i and fetch_err_o do not exist, and misalignment is silently masked.

Test Plan:
- Reset then ce_i=1, pc_i=0x0000_0000, gnt_i the cycle after req_o, rvalid_i the cycle after that with rdata_i=0x0010_0093 → req_o=1 with addr_o=0x0; inst_o=0x0010_0093, inst_pc_o=0x0, inst_valid_o=1 on cycle 3; stallreq_o=1 during REQ and WAIT.
- gnt_i delayed 4 cycles with pc_i=0x100 → req_o and addr_o=0x100 held stable for all 4 cycles; stallreq_o=1 throughout.
- branch_flag_i=1 in WAIT for addr 0x104, then rvalid_i=1 with rdata_i=0xDEAD_BEEF → word dropped, inst_valid_o=0, inst_o=0x0000_0013; next req_o uses new pc_i=0x200.
- stalled_i[1]=1 at capture of 0x0000_0513, held 3 cycles → inst_o is stable and no req_o in that window; fetch resumes the cycle after the stall releases.
- rst driven low mid-WAIT → all outputs return to reset values immediately (async); a late rvalid_i after reset release is ignored.
- IFU_FETCH_ERR_EN defined: rvalid_i=1 with err_i=1 → fetch_err_o=1 with inst_valid_o=1. pc_i=0x102 → fetch_err_o=1 and addr_o=0x100.

Source files
------------

// File: rtl/ifu_fetch.sv
// ============================================================================
// ifu_fetch : single-outstanding instruction fetch between PC and bus port
// Optional: define IFU_FETCH_ERR_EN to add err_i / fetch_err_o.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module ifu_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              branch_flag_i,
    input  logic [4:0]        stalled_i,
    output logic              req_o,
    output logic [ADDR_W-1:0] addr_o,
    input  logic              gnt_i,
    input  logic              rvalid_i,
    input  logic [DATA_W-1:0] rdata_i,
`ifdef IFU_FETCH_ERR_EN
    input  logic              err_i,
    output logic              fetch_err_o,
`endif
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    output logic              stallreq_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
    logic                valid_q, valid_d;
    logic                discard_q, discard_d;
    logic                issue;
    logic                capture;

`ifdef IFU_FETCH_ERR_EN
    logic                err_q, err_d;
`else
    logic                unused_inputs;
    assign unused_inputs = ^{pc_i[1:0], stalled_i[4:2], stalled_i[0]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            inst_q    <= NOP_INST;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            discard_q <= discard_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        discard_d = discard_q;
        issue     = 1'b0;
        capture   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ce_i && !branch_flag_i) issue = 1'b1;
            end
            S_REQ: begin
                // Request stays up on flush; the response is dropped later.
                if (branch_flag_i) discard_d = 1'b1;
                if (gnt_i) begin
                    req_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rvalid_i && !discard_q && !branch_flag_i) begin
                    capture = 1'b1;
                    if (stalled_i[1])  state_d = S_HOLD;
                    else if (ce_i)     issue   = 1'b1;
                    else               state_d = S_IDLE;
                end else if (rvalid_i) begin
                    // Response consumed but dropped (stale or flushed this cycle).
                    discard_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (branch_flag_i) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (branch_flag_i)     state_d = S_IDLE;
                else if (!stalled_i[1]) begin
                    if (ce_i) issue   = 1'b1;
                    else      state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            inst_d    = rdata_i;
            inst_pc_d = addr_q;
            valid_d   = 1'b1;
        end
        if (issue) begin
            req_d   = 1'b1;
            addr_d  = {pc_i[ADDR_W-1:2], 2'b00};
            state_d = S_REQ;
        end
        if (branch_flag_i) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end
    end

`ifdef IFU_FETCH_ERR_EN
    always_comb begin
        err_d = err_q;
        if (capture)                            err_d = err_i;
        if (issue && (pc_i[1:0] != 2'b00))      err_d = 1'b1;
        if (branch_flag_i)                      err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    logic unused_stall_bits;
    assign unused_stall_bits = ^{stalled_i[4:2], stalled_i[0]};
    assign fetch_err_o       = err_q;
`endif

    assign req_o        = req_q;
    assign addr_o       = addr_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = valid_q;
    assign stallreq_o   = (state_q == S_REQ) || (state_q == S_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// tb_ifu_fetch : scoreboard bench for ifu_fetch
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_i = '0;
    logic        ce_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [4:0]  stalled_i = '0;
    logic        req_o;
    logic [31:0] addr_o;
    logic        gnt_i = 1'b0;
    logic        rvalid_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        stallreq_o;
`ifdef IFU_FETCH_ERR_EN
    logic        err_i = 1'b0;
    logic        fetch_err_o;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] sb_q[$];
    logic [63:0] exp_e;

    ifu_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .branch_flag_i(branch_flag_i),
        .stalled_i    (stalled_i),
        .req_o        (req_o),
        .addr_o       (addr_o),
        .gnt_i        (gnt_i),
        .rvalid_i     (rvalid_i),
        .rdata_i      (rdata_i),
`ifdef IFU_FETCH_ERR_EN
        .err_i        (err_i),
        .fetch_err_o  (fetch_err_o),
`endif
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Protocol watch: a pending request must not drop or move without a grant.
    logic        p_req = 1'b0, p_gnt = 1'b0, p_rst = 1'b0;
    logic [31:0] p_addr = '0;
    always @(negedge clk) begin
        if (p_rst && rst && p_req && !p_gnt) begin
            vectors++;
            if (req_o !== 1'b1 || addr_o !== p_addr) begin
                miscompares++;
                $display("FAIL req_hold: req=%0b addr=%h, expected req=1 addr=%h", req_o, addr_o, p_addr);
            end
        end
        p_req = req_o; p_gnt = gnt_i; p_rst = rst; p_addr = addr_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] data, input logic [31:0] pc);
        sb_q.push_back({data, pc});
    endtask

    task automatic check_capture(input string name);
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: capture seen with empty scoreboard", name);
        end else begin
            exp_e = sb_q.pop_front();
            if (inst_o !== exp_e[63:32] || inst_pc_o !== exp_e[31:0] || inst_valid_o !== 1'b1) begin
                miscompares++;
                $display("FAIL %s: inst=%h pc=%h v=%0b, expected inst=%h pc=%h v=1",
                         name, inst_o, inst_pc_o, inst_valid_o, exp_e[63:32], exp_e[31:0]);
            end
        end
    endtask

    // Issue a fetch, grant it next cycle, leave DUT in WAIT.
    task automatic to_wait(input logic [31:0] pc);
        pc_i = pc; ce_i = 1'b1; step();
        ce_i = 1'b0; gnt_i = 1'b1; step();
        gnt_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic [31:0] pc, input string name);
        rvalid_i = 1'b1; rdata_i = data; expect_word(data, pc); step();
        rvalid_i = 1'b0;
        check_capture(name);
    endtask

    task automatic test_reset();
        rst = 1'b0; step(); step();
        vectors++;
        if (req_o !== 1'b0 || addr_o !== 32'h0 || inst_o !== NOP || inst_pc_o !== 32'h0 ||
            inst_valid_o !== 1'b0 || stallreq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: req=%0b addr=%h inst=%h pc=%h v=%0b st=%0b, expected 0/0/%h/0/0/0",
                     req_o, addr_o, inst_o, inst_pc_o, inst_valid_o, stallreq_o, NOP);
        end
        rst = 1'b1; step();
    endtask

    task automatic test_basic();
        pc_i = 32'h0; ce_i = 1'b1; step();
        vectors++;
        if (req_o !== 1'b1 || addr_o !== 32'h0 || stallreq_o !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_req: req=%0b addr=%h st=%0b, expected 1/0/1", req_o, addr_o, stallreq_o);
        end
        ce_i = 1'b0; gnt_i = 1'b1; step();
        gnt_i = 1'b0;
        vectors++;
        if (req_o !== 1'b0 || stallreq_o !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_wait: req=%0b st=%0b, expected 0/1", req_o, stallreq_o);
        end
        respond(32'h0010_0093, 32'h0, "basic_capture");
        vectors++;
        if (stallreq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_idle: st=%0b, expected 0", stallreq_o);
        end
    endtask

    task automatic test_gnt_delay();
        pc_i = 32'h100; ce_i = 1'b1; step();
        ce_i = 1'b0; pc_i = 32'h180;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (req_o !== 1'b1 || addr_o !== 32'h100 || stallreq_o !== 1'b1) begin
                miscompares++;
                $display("FAIL gnt_delay[%0d]: req=%0b addr=%h st=%0b, expected 1/100/1", i, req_o, addr_o, stallreq_o);
            end
            step();
        end
        gnt_i = 1'b1; step(); gnt_i = 1'b0;
        respond(32'h00A0_0113, 32'h100, "gnt_delay_capture");
    endtask

    task automatic test_flush();
        to_wait(32'h104);
        branch_flag_i = 1'b1; pc_i = 32'h200; step();
        branch_flag_i = 1'b0;
        vectors++;
        if (inst_valid_o !== 1'b0 || inst_o !== NOP || stallreq_o !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_wait: v=%0b inst=%h st=%0b, expected 0/%h/1", inst_valid_o, inst_o, stallreq_o, NOP);
        end
        rvalid_i = 1'b1; rdata_i = 32'hDEAD_BEEF; ce_i = 1'b1; step();
        rvalid_i = 1'b0;
        vectors++;
        if (inst_valid_o !== 1'b0 || inst_o !== NOP || req_o !== 1'b0 || stallreq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drop: v=%0b inst=%h req=%0b st=%0b, expected 0/%h/0/0",
                     inst_valid_o, inst_o, req_o, stallreq_o, NOP);
        end
        step(); ce_i = 1'b0;
        vectors++;
        if (req_o !== 1'b1 || addr_o !== 32'h200) begin
            miscompares++;
            $display("FAIL flush_refetch: req=%0b addr=%h, expected 1/200", req_o, addr_o);
        end
        gnt_i = 1'b1; step(); gnt_i = 1'b0;
        respond(32'h0000_0593, 32'h200, "flush_refetch_capture");
        // Branch and response in the same cycle: flush wins, no stale discard left.
        to_wait(32'h300);
        branch_flag_i = 1'b1; rvalid_i = 1'b1; rdata_i = 32'h1111_1111; step();
        branch_flag_i = 1'b0; rvalid_i = 1'b0;
        vectors++;
        if (inst_valid_o !== 1'b0 || inst_o !== NOP || stallreq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_rvalid: v=%0b inst=%h st=%0b, expected 0/%h/0", inst_valid_o, inst_o, stallreq_o, NOP);
        end
        to_wait(32'h304);
        respond(32'h2222_2222, 32'h304, "after_flush_rvalid");
    endtask

    task automatic test_hold_back_to_back();
        to_wait(32'h400);
        stalled_i = 5'b00010; ce_i = 1'b1; pc_i = 32'h404;
        respond(32'h0000_0513, 32'h400, "hold_capture");
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (inst_o !== 32'h0000_0513 || inst_valid_o !== 1'b1 || req_o !== 1'b0 || stallreq_o !== 1'b0) begin
                miscompares++;
                $display("FAIL hold[%0d]: inst=%h v=%0b req=%0b st=%0b, expected 00000513/1/0/0",
                         i, inst_o, inst_valid_o, req_o, stallreq_o);
            end
        end
        stalled_i = 5'b0; step();
        vectors++;
        if (req_o !== 1'b1 || addr_o !== 32'h404) begin
            miscompares++;
            $display("FAIL hold_resume: req=%0b addr=%h, expected 1/404", req_o, addr_o);
        end
        ce_i = 1'b0; gnt_i = 1'b1; step(); gnt_i = 1'b0;
        ce_i = 1'b1; pc_i = 32'h40A;
        respond(32'h0015_0513, 32'h404, "b2b_first");
        ce_i = 1'b0;
        vectors++;
        if (req_o !== 1'b1 || addr_o !== 32'h408) begin
            miscompares++;
            $display("FAIL b2b_issue: req=%0b addr=%h, expected 1/408", req_o, addr_o);
        end
        gnt_i = 1'b1; step(); gnt_i = 1'b0;
        respond(32'h0025_0513, 32'h408, "b2b_second");
    endtask

    task automatic test_async_reset();
        to_wait(32'h500);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (req_o !== 1'b0 || addr_o !== 32'h0 || inst_o !== NOP || inst_pc_o !== 32'h0 ||
            inst_valid_o !== 1'b0 || stallreq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: req=%0b addr=%h inst=%h pc=%h v=%0b st=%0b, expected 0/0/%h/0/0/0",
                     req_o, addr_o, inst_o, inst_pc_o, inst_valid_o, stallreq_o, NOP);
        end
        step();
        rst = 1'b1; rvalid_i = 1'b1; rdata_i = 32'hBAD0_BAD0; step();
        rvalid_i = 1'b0;
        vectors++;
        if (inst_valid_o !== 1'b0 || inst_o !== NOP || stallreq_o !== 1'b0 || req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL late_rvalid: v=%0b inst=%h st=%0b req=%0b, expected 0/%h/0/0",
                     inst_valid_o, inst_o, stallreq_o, req_o, NOP);
        end
    endtask

`ifdef IFU_FETCH_ERR_EN
    task automatic test_err();
        to_wait(32'h600);
        respond(32'h0000_0013, 32'h600, "err_clean");
        vectors++;
        if (fetch_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clean_flag: fetch_err=%0b, expected 0", fetch_err_o);
        end
        pc_i = 32'h102; ce_i = 1'b1; step(); ce_i = 1'b0;
        vectors++;
        if (fetch_err_o !== 1'b1 || addr_o !== 32'h100 || req_o !== 1'b1) begin
            miscompares++;
            $display("FAIL err_misalign: fetch_err=%0b addr=%h req=%0b, expected 1/100/1", fetch_err_o, addr_o, req_o);
        end
        gnt_i = 1'b1; step(); gnt_i = 1'b0;
        err_i = 1'b1;
        respond(32'h0030_0193, 32'h100, "err_bus");
        err_i = 1'b0;
        vectors++;
        if (fetch_err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL err_bus_flag: fetch_err=%0b, expected 1", fetch_err_o);
        end
        branch_flag_i = 1'b1; step(); branch_flag_i = 1'b0;
        vectors++;
        if (fetch_err_o !== 1'b0 || inst_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL err_flush: fetch_err=%0b v=%0b, expected 0/0", fetch_err_o, inst_valid_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gnt_delay();
        test_flush();
        test_hold_back_to_back();
        test_async_reset();
`ifdef IFU_FETCH_ERR_EN
        test_err();
`endif
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
